// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: signed/unsigned, WIDTH-bit operands, one quotient bit per cycle.
// Divide-by-zero and signed MIN / -1 produce fixed results with flags; busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    // Two's-complement negation; MIN maps onto itself, read as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return ~v + LSB_ONE;
    endfunction

    state_t           state_r, state_s;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] acc_r, quo_r, dvs_mag_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r, neg_r_r, ovf_pend_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_r, ovf_r;

    logic             accept_s, zero_div_s, dvd_neg_s, dvs_neg_s, sub_ok_s;
    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s, a_diff_s;
    logic [WIDTH:0]   a_shift_s;

    assign accept_s   = (state_r == IDLE) && start;
    assign zero_div_s = (divisor == ZERO);
    assign dvd_neg_s  = signed_op & dividend[WIDTH-1];
    assign dvs_neg_s  = signed_op & divisor[WIDTH-1];
    assign dvd_mag_s  = dvd_neg_s ? neg_val(dividend) : dividend;
    assign dvs_mag_s  = dvs_neg_s ? neg_val(divisor) : divisor;
    assign a_shift_s  = {acc_r, quo_r[WIDTH-1]};
    assign sub_ok_s   = (a_shift_s >= {1'b0, dvs_mag_r});
    // True difference is below 2^WIDTH whenever it is kept, so modular WIDTH-bit subtract suffices.
    assign a_diff_s   = a_shift_s[WIDTH-1:0] - dvs_mag_r;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = zero_div_s ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN) || (state_s == FIX);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, shift/subtract iteration and sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= ZERO;
            quo_r       <= ZERO;
            dvs_mag_r   <= ZERO;
            cnt_r       <= {CNT_W{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ovf_pend_r  <= 1'b0;
            quotient_r  <= ZERO;
            remainder_r <= ZERO;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
            if (zero_div_s) begin
                quotient_r  <= ONES;
                remainder_r <= dividend;
                dbz_r       <= 1'b1;
            end else begin
                acc_r      <= ZERO;
                quo_r      <= dvd_mag_s;
                dvs_mag_r  <= dvs_mag_s;
                cnt_r      <= CNT_INIT;
                neg_q_r    <= dvd_neg_s ^ dvs_neg_s;
                neg_r_r    <= dvd_neg_s;
                ovf_pend_r <= signed_op && (dividend == MIN_VAL) && (divisor == ONES);
            end
        end else if (state_r == RUN) begin
            acc_r <= sub_ok_s ? a_diff_s : a_shift_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], sub_ok_s};
            cnt_r <= cnt_r - CNT_ONE;
        end else if (state_r == FIX) begin
            quotient_r  <= neg_q_r ? neg_val(quo_r) : quo_r;
            remainder_r <= neg_r_r ? neg_val(acc_r) : acc_r;
            ovf_r       <= ovf_pend_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 32-bit instance for function/handshake/reset, 8-bit instance for width.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, sd32, busy32, done32, dbz32, ovf32;
    logic [31:0] a32, b32, quotient32, remainder32;
    logic        start8, sd8, busy8, done8, dbz8, ovf8;
    logic [7:0]  a8, b8, quotient8, remainder8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_op(sd32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(quotient32), .remainder(remainder32),
        .div_by_zero(dbz32), .overflow(ovf32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(sd8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one 32-bit op; optionally pulse a second start at negedge 'inject'.
    task automatic run32(input logic sd, input logic [31:0] a, input logic [31:0] b, input int inject,
                         output int lat, output int bcnt, output logic [31:0] q1, output logic dz1);
        @(negedge clk);
        sd32 = sd; a32 = a; b32 = b; start32 = 1'b1;
        lat = 0; bcnt = 0; q1 = 32'h0; dz1 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (i == 1) begin
                q1 = quotient32;
                dz1 = dbz32;
            end
            if (inject != 0 && i == inject) begin
                a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
            end
            if (busy32) bcnt++;
            if (done32) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_val("timeout32", 64'd0, 64'd1);
    endtask

    task automatic run8(input logic sd, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        sd8 = sd; a8 = a; b8 = b; start8 = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_val("timeout8", 64'd0, 64'd1);
    endtask

    initial begin
        int          lat, bcnt, d1, d2;
        logic [31:0] q1;
        logic        dz1;

        rst_n = 1'b0;
        start32 = 1'b0; sd32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
        start8 = 1'b0; sd8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {63'd0, busy32}, 64'd0);
        check_val("rst_done", {63'd0, done32}, 64'd0);
        check_val("rst_q", {32'd0, quotient32}, 64'd0);
        check_val("rst_r", {32'd0, remainder32}, 64'd0);
        check_val("rst_flags", {62'd0, dbz32, ovf32}, 64'd0);
        rst_n = 1'b1;

        run32(1'b0, 32'd100, 32'd7, 0, lat, bcnt, q1, dz1);
        check_val("u100_7_q", {32'd0, quotient32}, 64'd14);
        check_val("u100_7_r", {32'd0, remainder32}, 64'd2);
        check_val("u100_7_lat", lat, 64'd34);
        check_val("u100_7_busy", bcnt, 64'd33);
        check_val("u100_7_flags", {62'd0, dbz32, ovf32}, 64'd0);

        run32(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, q1, dz1);
        check_val("sm7_2_q", {32'd0, quotient32}, 64'hFFFF_FFFD);
        check_val("sm7_2_r", {32'd0, remainder32}, 64'hFFFF_FFFF);

        run32(1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt, q1, dz1);
        check_val("s7_m2_q", {32'd0, quotient32}, 64'hFFFF_FFFD);
        check_val("s7_m2_r", {32'd0, remainder32}, 64'd1);

        run32(1'b0, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, q1, dz1);
        check_val("uFFF9_2_q", {32'd0, quotient32}, 64'h7FFF_FFFC);
        check_val("uFFF9_2_r", {32'd0, remainder32}, 64'd1);

        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt, q1, dz1);
        check_val("ovf_q", {32'd0, quotient32}, 64'h8000_0000);
        check_val("ovf_r", {32'd0, remainder32}, 64'd0);
        check_val("ovf_flag", {63'd0, ovf32}, 64'd1);
        check_val("ovf_dbz", {63'd0, dbz32}, 64'd0);

        run32(1'b0, 32'd1234, 32'd0, 0, lat, bcnt, q1, dz1);
        check_val("dbz_q", {32'd0, quotient32}, 64'hFFFF_FFFF);
        check_val("dbz_r", {32'd0, remainder32}, 64'd1234);
        check_val("dbz_flag", {63'd0, dbz32}, 64'd1);
        check_val("dbz_ovf", {63'd0, ovf32}, 64'd0);
        check_val("dbz_lat", lat, 64'd1);
        check_val("dbz_busy", bcnt, 64'd0);

        // Second start in mid-RUN must be dropped; old result held, flag cleared at accept.
        run32(1'b0, 32'd1000, 32'd10, 5, lat, bcnt, q1, dz1);
        check_val("hold_q", {32'd0, q1}, 64'hFFFF_FFFF);
        check_val("clr_dbz", {63'd0, dz1}, 64'd0);
        check_val("ign_q", {32'd0, quotient32}, 64'd100);
        check_val("ign_r", {32'd0, remainder32}, 64'd0);
        check_val("ign_lat", lat, 64'd34);
        repeat (3) @(negedge clk);
        check_val("ign_no_relaunch", {63'd0, busy32}, 64'd0);

        // start held high: back-to-back ops 35 cycles apart.
        @(negedge clk);
        sd32 = 1'b0; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done32) begin
                if (d1 == 0) begin
                    d1 = i;
                end else begin
                    d2 = i;
                    start32 = 1'b0;
                    break;
                end
            end
        end
        start32 = 1'b0;
        check_val("b2b_first", d1, 64'd34);
        check_val("b2b_spacing", d2 - d1, 64'd35);
        check_val("b2b_q", {32'd0, quotient32}, 64'd10);

        // Asynchronous reset at iteration 10.
        @(negedge clk);
        sd32 = 1'b0; a32 = 32'd1000; b32 = 32'd10; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        check_val("pre_rst_busy", {63'd0, busy32}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", {63'd0, busy32}, 64'd0);
        check_val("arst_q", {32'd0, quotient32}, 64'd0);
        check_val("arst_r", {32'd0, remainder32}, 64'd0);
        check_val("arst_done", {63'd0, done32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run32(1'b0, 32'd15, 32'd4, 0, lat, bcnt, q1, dz1);
        check_val("post_rst_q", {32'd0, quotient32}, 64'd3);
        check_val("post_rst_r", {32'd0, remainder32}, 64'd3);
        check_val("post_rst_lat", lat, 64'd34);

        // 8-bit instance.
        run8(1'b1, 8'h80, 8'd3, lat);
        check_val("w8_m128_3_q", {56'd0, quotient8}, 64'hD6);
        check_val("w8_m128_3_r", {56'd0, remainder8}, 64'hFE);
        check_val("w8_lat", lat, 64'd10);
        run8(1'b1, 8'h9C, 8'hF9, lat);
        check_val("w8_m100_m7_q", {56'd0, quotient8}, 64'h0E);
        check_val("w8_m100_m7_r", {56'd0, remainder8}, 64'hFE);
        run8(1'b0, 8'd200, 8'd16, lat);
        check_val("w8_u200_16_q", {56'd0, quotient8}, 64'h0C);
        check_val("w8_u200_16_r", {56'd0, remainder8}, 64'h08);
        run8(1'b1, 8'h80, 8'hFF, lat);
        check_val("w8_ovf_q", {56'd0, quotient8}, 64'h80);
        check_val("w8_ovf_r", {56'd0, remainder8}, 64'h00);
        check_val("w8_ovf_flag", {63'd0, ovf8}, 64'd1);
        run8(1'b0, 8'h80, 8'hFF, lat);
        check_val("w8_u128_255_q", {56'd0, quotient8}, 64'h00);
        check_val("w8_u128_255_r", {56'd0, remainder8}, 64'h80);
        check_val("w8_u_ovf_flag", {63'd0, ovf8}, 64'd0);
        run8(1'b1, 8'h7F, 8'h80, lat);
        check_val("w8_127_m128_q", {56'd0, quotient8}, 64'h00);
        check_val("w8_127_m128_r", {56'd0, remainder8}, 64'h7F);
        run8(1'b1, 8'hF6, 8'h00, lat);
        check_val("w8_dbz_q", {56'd0, quotient8}, 64'hFF);
        check_val("w8_dbz_r", {56'd0, remainder8}, 64'hF6);
        check_val("w8_dbz_lat", lat, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
